report_arbiter: RTL and testbench
=================================

REPORT_ARBITER -- requirements
Module: report_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 2_000_000, max cycles to wait for report completion.
REQ-002 SHALL have parameter GAP_CYC, default 4, idle cycles between reports; minimum 1.
REQ-003 SHALL have port iClk input 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port iRstn input 1: reset, asynchronous, active-low.
REQ-005 SHALL have port i_en input 1: high permits new grants.
REQ-006 SHALL have port i_req input 4: per-source one-cycle request pulses; bit0 TIME, bit1 STATE, bit2 SR04, bit3 DHT11.
REQ-007 SHALL have ports i_time_data, i_state_data, i_sr04_data, i_dht_data, each input 32: per-source payload words.
REQ-008 SHALL have port i_tx_valid input 1: sender byte-valid strobe, monitored.
REQ-009 SHALL have port i_tx_data input 8: sender byte, monitored.
REQ-010 SHALL have port i_clr_drop input 1: clears o_drop.
REQ-011 SHALL have port o_c_mode output 2: mode to sender, equal to granted source index.
REQ-012 SHALL have port o_start output 1: one-cycle start pulse to sender.
REQ-013 SHALL have port o_dec_data output 32: payload to sender.
REQ-014 SHALL have port o_busy output 1: high when state is not IDLE.
REQ-015 SHALL have port o_pending output 4: latched outstanding requests.
REQ-016 SHALL have port o_drop output 4: sticky per-source overrun flags.
REQ-017 SHALL have port o_timeout output 1: one-cycle pulse on watchdog expiry.

Function
REQ-018 SHALL set pending[k] on i_req[k] and clear it on grant of k; a simultaneous set and clear leaves it set.
REQ-019 SHALL set o_drop[k] when i_req[k] arrives while pending[k] is already set and not being cleared; i_clr_drop clears it, and a simultaneous set wins.
REQ-020 SHALL implement states IDLE, WAIT_DONE and GAP.
REQ-021 In IDLE with i_en=1 and pending!=0, SHALL on the next edge grant exactly one source, register o_start=1, o_c_mode=k and o_dec_data=data_k (snapshot at that edge), clear pending[k], and go to WAIT_DONE.
REQ-022 Request-to-start latency SHALL be one edge: req sampled at edge E0 gives o_start high from E1 to E2.
REQ-023 SHALL deassert o_start after exactly one cycle; o_c_mode and o_dec_data SHALL hold until the next grant.
REQ-024 SHALL grant round-robin: search starts at pointer ptr and runs ptr, ptr+1, ... mod 4; after granting k, ptr becomes (k+1) mod 4.
REQ-025 In WAIT_DONE, i_tx_valid=1 with i_tx_data=0x0A SHALL end the report and go to GAP.
REQ-026 In WAIT_DONE, SHALL count cycles; at count TIMEOUT_CYC-1 without LF, SHALL pulse o_timeout and go to GAP.
REQ-027 SHALL ignore LF bytes seen outside WAIT_DONE.
REQ-028 SHALL stay in GAP for exactly GAP_CYC cycles, then return to IDLE.
REQ-029 i_en=0 SHALL block new grants only; an in-flight report SHALL complete, and pending SHALL keep latching.

Reset
REQ-030 On iRstn low, SHALL immediately force state=IDLE, ptr=0, pending=0, all counters 0, o_start=0, o_c_mode=0, o_dec_data=0, o_drop=0, o_timeout=0, o_busy=0.
REQ-031 Reset mid-report SHALL abort the report without later completion, timeout or grant side effects.

Structure
REQ-032 Mode codes (TIME=0, STATE=1, SR04=2, DHT11=3), the ASCII_LF constant and the state encodings SHALL live in the shared package used by the sender.
REQ-033 Round-robin selection SHALL be a combinational sub-module rr_pick4 taking pending and ptr and returning valid and a 2-bit index.

Verification
REQ-034 i_req=4'b0100 with i_sr04_data=0x00012345 -> o_start high one cycle after, o_c_mode=2, o_dec_data=0x00012345, o_busy=1.
REQ-035 i_req=4'b1111 in one cycle at ptr=0 -> grants in order 0,1,2,3, each after an LF and a 4-cycle gap; o_drop=0.
REQ-036 Second i_req[1] while pending[1] is set -> o_drop[1]=1, one grant only; i_clr_drop -> o_drop=0.
REQ-037 Grant with no LF, TIMEOUT_CYC=16 -> o_timeout pulses 16 cycles after WAIT_DONE entry, then GAP, then IDLE.
REQ-038 iRstn low during WAIT_DONE with pending=4'b1000 -> all outputs 0, and no o_start after release until a new request.
REQ-039 i_en=0 with i_req[0] pulsed -> no o_start, o_pending=4'b0001; i_en raised -> o_start on the next edge with o_c_mode=0.

Source files
------------

// File: rtl/report_arbiter_pkg.sv
// Shared definitions for the report arbiter and the report sender:
// mode codes, line terminator and arbiter state encodings.
package report_arbiter_pkg;

    localparam logic [1:0] MODE_TIME  = 2'd0;
    localparam logic [1:0] MODE_STATE = 2'd1;
    localparam logic [1:0] MODE_SR04  = 2'd2;
    localparam logic [1:0] MODE_DHT11 = 2'd3;

    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_DONE = 2'd1;
    localparam logic [1:0] ST_GAP       = 2'd2;

    typedef struct packed {
        logic [1:0]  mode;
        logic [31:0] data;
    } grant_t;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/report_arbiter_rr_pick4.sv
// Combinational 4-way round-robin picker: first set bit of pending_i
// searching ptr_i, ptr_i+1, ... modulo 4.
module rr_pick4 (
    input  logic [3:0] pending_i,
    input  logic [1:0] ptr_i,
    output logic       valid_o,
    output logic [1:0] idx_o
);

    logic [1:0] cand;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = ptr_i;
        cand    = ptr_i;
        // Walk from the farthest offset down so the nearest hit is the last write.
        for (int i = 3; i >= 0; i--) begin
            cand = ptr_i + 2'(i);
            if (pending_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/report_arbiter.sv
// Round-robin arbiter that latches per-source report requests and hands one
// report at a time to the sender, waiting for its LF or a watchdog timeout.
//
// state      | meaning
// IDLE       | no report in flight; grants when enabled and requests pending
// WAIT_DONE  | report granted; waiting for LF byte from sender or timeout
// GAP        | enforced idle spacing of GAP_CYC cycles before next grant
module report_arbiter
    import report_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 2_000_000,
    parameter int unsigned GAP_CYC     = 4
) (
    input  logic        iClk,
    input  logic        iRstn,
    input  logic        i_en,
    input  logic [3:0]  i_req,
    input  logic [31:0] i_time_data,
    input  logic [31:0] i_state_data,
    input  logic [31:0] i_sr04_data,
    input  logic [31:0] i_dht_data,
    input  logic        i_tx_valid,
    input  logic [7:0]  i_tx_data,
    input  logic        i_clr_drop,
    output logic [1:0]  o_c_mode,
    output logic        o_start,
    output logic [31:0] o_dec_data,
    output logic        o_busy,
    output logic [3:0]  o_pending,
    output logic [3:0]  o_drop,
    output logic        o_timeout
);

    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] GAP_LAST = 32'(GAP_CYC - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [3:0]  pending_q, pending_d;
    logic [3:0]  drop_q, drop_d;
    logic [31:0] cnt_q, cnt_d;
    logic        start_q, start_d;
    logic        timeout_q, timeout_d;
    grant_t      grant_q, grant_d;

    logic        pick_valid;
    logic [1:0]  pick_idx;
    logic        grant;
    logic [3:0]  clr_mask;
    logic        lf_seen;
    logic [31:0] payload;

    rr_pick4 u_pick (
        .pending_i (pending_q),
        .ptr_i     (ptr_q),
        .valid_o   (pick_valid),
        .idx_o     (pick_idx)
    );

    assign grant    = (state_q == ST_IDLE) && i_en && pick_valid;
    assign clr_mask = grant ? (4'b0001 << pick_idx) : 4'b0000;
    assign lf_seen  = i_tx_valid && (i_tx_data == ASCII_LF);

    always_comb begin
        payload = i_time_data;
        case (pick_idx)
            MODE_TIME:  payload = i_time_data;
            MODE_STATE: payload = i_state_data;
            MODE_SR04:  payload = i_sr04_data;
            MODE_DHT11: payload = i_dht_data;
            default:    payload = i_time_data;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        start_d   = 1'b0;
        timeout_d = 1'b0;
        grant_d   = grant_q;
        // New requests win over a same-cycle grant clear or drop clear.
        pending_d = (pending_q & ~clr_mask) | i_req;
        drop_d    = (i_clr_drop ? 4'b0000 : drop_q) | (i_req & pending_q & ~clr_mask);

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d      = ST_WAIT_DONE;
                    ptr_d        = rr_next(pick_idx);
                    start_d      = 1'b1;
                    grant_d.mode = pick_idx;
                    grant_d.data = payload;
                    cnt_d        = TO_LAST;
                end
            end
            ST_WAIT_DONE: begin
                if (lf_seen) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LAST;
                end else if (cnt_q == 32'd0) begin
                    timeout_d = 1'b1;
                    state_d   = ST_GAP;
                    cnt_d     = GAP_LAST;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 32'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 32'd0;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd0;
            pending_q <= 4'b0000;
            drop_q    <= 4'b0000;
            cnt_q     <= 32'd0;
            start_q   <= 1'b0;
            timeout_q <= 1'b0;
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            timeout_q <= timeout_d;
            grant_q   <= grant_d;
        end
    end

    assign o_c_mode   = grant_q.mode;
    assign o_dec_data = grant_q.data;
    assign o_start    = start_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_pending  = pending_q;
    assign o_drop     = drop_q;
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_report_arbiter.sv
// Self-checking bench for report_arbiter: a negedge monitor pops expected
// grants from a scoreboard queue; directed sequences cover timing and flags.
module tb_report_arbiter;

    localparam int unsigned TO_CYC  = 16;
    localparam int unsigned GAP_CYC = 4;

    logic        iClk = 1'b0;
    logic        iRstn;
    logic        i_en;
    logic [3:0]  i_req;
    logic [31:0] i_time_data, i_state_data, i_sr04_data, i_dht_data;
    logic        i_tx_valid;
    logic [7:0]  i_tx_data;
    logic        i_clr_drop;
    logic [1:0]  o_c_mode;
    logic        o_start;
    logic [31:0] o_dec_data;
    logic        o_busy;
    logic [3:0]  o_pending;
    logic [3:0]  o_drop;
    logic        o_timeout;

    typedef struct packed {
        logic [1:0]  mode;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    logic prev_start = 1'b0;

    report_arbiter #(.TIMEOUT_CYC(TO_CYC), .GAP_CYC(GAP_CYC)) dut (
        .iClk         (iClk),
        .iRstn        (iRstn),
        .i_en         (i_en),
        .i_req        (i_req),
        .i_time_data  (i_time_data),
        .i_state_data (i_state_data),
        .i_sr04_data  (i_sr04_data),
        .i_dht_data   (i_dht_data),
        .i_tx_valid   (i_tx_valid),
        .i_tx_data    (i_tx_data),
        .i_clr_drop   (i_clr_drop),
        .o_c_mode     (o_c_mode),
        .o_start      (o_start),
        .o_dec_data   (o_dec_data),
        .o_busy       (o_busy),
        .o_pending    (o_pending),
        .o_drop       (o_drop),
        .o_timeout    (o_timeout)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge iClk) begin
        if (o_start) begin
            chk("start_width", 32'(prev_start), 32'd0);
            if (sb_q.size() == 0) begin
                chk("start_unexpected", 32'(o_start), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("grant_mode", 32'(o_c_mode), 32'(mon_e.mode));
                chk("grant_data", o_dec_data, mon_e.data);
                chk("grant_busy", 32'(o_busy), 32'd1);
            end
        end
        prev_start = o_start;
    end

    task automatic pulse_req(input logic [3:0] v);
        i_req = v;
        @(negedge iClk);
        i_req = 4'b0000;
    endtask

    task automatic send_lf();
        i_tx_valid = 1'b1;
        i_tx_data  = 8'h0A;
        @(negedge iClk);
        i_tx_valid = 1'b0;
        i_tx_data  = 8'h00;
    endtask

    task automatic push_exp(input logic [1:0] m, input logic [31:0] d);
        exp_t e;
        e.mode = m;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic cycles_to_start(output int n);
        n = 0;
        while (!o_start && n < 100) begin
            @(negedge iClk);
            n++;
        end
        chk("start_seen", 32'(o_start), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (o_busy && n < 100) begin
            @(negedge iClk);
            n++;
        end
        chk("idle_reached", 32'(o_busy), 32'd0);
    endtask

    task automatic apply_reset();
        iRstn = 1'b0;
        repeat (3) @(negedge iClk);
        iRstn = 1'b1;
        @(negedge iClk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int   n;
        logic saw;
        iRstn        = 1'b0;
        i_en         = 1'b1;
        i_req        = 4'b0000;
        i_time_data  = 32'h1111_0000;
        i_state_data = 32'h2222_0001;
        i_sr04_data  = 32'h0001_2345;
        i_dht_data   = 32'h4444_0003;
        i_tx_valid   = 1'b0;
        i_tx_data    = 8'h00;
        i_clr_drop   = 1'b0;
        repeat (3) @(negedge iClk);

        chk("rst_start",   32'(o_start),   32'd0);
        chk("rst_mode",    32'(o_c_mode),  32'd0);
        chk("rst_data",    o_dec_data,     32'd0);
        chk("rst_busy",    32'(o_busy),    32'd0);
        chk("rst_pending", 32'(o_pending), 32'd0);
        chk("rst_drop",    32'(o_drop),    32'd0);
        chk("rst_timeout", 32'(o_timeout), 32'd0);
        iRstn = 1'b1;
        @(negedge iClk);

        // Single SR04 request: one-edge latency, payload snapshot held afterwards
        push_exp(2'd2, 32'h0001_2345);
        pulse_req(4'b0100);
        chk("lat_before",  32'(o_start),   32'd0);
        chk("pend_sr04",   32'(o_pending), 32'b0100);
        @(negedge iClk);
        chk("lat_start",   32'(o_start),   32'd1);
        chk("sr04_mode",   32'(o_c_mode),  32'd2);
        chk("sr04_busy",   32'(o_busy),    32'd1);
        i_sr04_data = 32'hDEAD_BEEF;
        @(negedge iClk);
        chk("start_fall",  32'(o_start),   32'd0);
        chk("data_hold",   o_dec_data,     32'h0001_2345);
        send_lf();
        wait_idle();

        // All four at once from ptr=0: order 0,1,2,3 with a fixed gap
        apply_reset();
        i_sr04_data = 32'h3333_0002;
        push_exp(2'd0, i_time_data);
        push_exp(2'd1, i_state_data);
        push_exp(2'd2, i_sr04_data);
        push_exp(2'd3, i_dht_data);
        pulse_req(4'b1111);
        cycles_to_start(n);
        for (int k = 0; k < 3; k++) begin
            send_lf();
            cycles_to_start(n);
            chk("gap_len", 32'(n), 32'(GAP_CYC + 1));
        end
        send_lf();
        wait_idle();
        chk("all4_drop", 32'(o_drop), 32'd0);

        // Overrun on STATE while blocked; drop set beats clear; one grant only
        i_en = 1'b0;
        pulse_req(4'b0010);
        pulse_req(4'b0010);
        chk("drop_set",    32'(o_drop),    32'b0010);
        chk("drop_pend",   32'(o_pending), 32'b0010);
        i_req      = 4'b0010;
        i_clr_drop = 1'b1;
        @(negedge iClk);
        i_req      = 4'b0000;
        chk("drop_set_wins", 32'(o_drop), 32'b0010);
        @(negedge iClk);
        i_clr_drop = 1'b0;
        chk("drop_clr",    32'(o_drop),    32'd0);
        push_exp(2'd1, i_state_data);
        i_en = 1'b1;
        cycles_to_start(n);
        send_lf();
        wait_idle();
        repeat (3) @(negedge iClk);
        chk("drop_pend_empty", 32'(o_pending), 32'd0);

        // Watchdog; an LF on the grant edge (still IDLE) must be ignored
        push_exp(2'd3, i_dht_data);
        pulse_req(4'b1000);
        i_tx_valid = 1'b1;
        i_tx_data  = 8'h0A;
        @(negedge iClk);
        i_tx_valid = 1'b0;
        i_tx_data  = 8'h00;
        chk("to_start", 32'(o_start), 32'd1);
        n = 0;
        while (!o_timeout && n < 100) begin
            @(negedge iClk);
            n++;
        end
        chk("to_delay",   32'(n),      32'(TO_CYC));
        chk("to_in_gap",  32'(o_busy), 32'd1);
        @(negedge iClk);
        n = 1;
        chk("to_width",   32'(o_timeout), 32'd0);
        while (o_busy && n < 100) begin
            @(negedge iClk);
            n++;
        end
        chk("to_gap_len", 32'(n), 32'(GAP_CYC));

        // Enable gating: request latches but waits for i_en
        i_en = 1'b0;
        pulse_req(4'b0001);
        repeat (3) @(negedge iClk);
        chk("en_no_start", 32'(o_start),   32'd0);
        chk("en_pending",  32'(o_pending), 32'b0001);
        push_exp(2'd0, i_time_data);
        i_en = 1'b1;
        @(negedge iClk);
        chk("en_start",    32'(o_start),   32'd1);
        chk("en_mode",     32'(o_c_mode),  32'd0);
        send_lf();
        wait_idle();

        // Pointer now 1: DHT11 then TIME (wrap-around)
        i_en = 1'b0;
        pulse_req(4'b1001);
        push_exp(2'd3, i_dht_data);
        push_exp(2'd0, i_time_data);
        i_en = 1'b1;
        cycles_to_start(n);
        send_lf();
        cycles_to_start(n);
        send_lf();
        wait_idle();

        // Async reset during WAIT_DONE with DHT11 pending
        push_exp(2'd0, i_time_data);
        pulse_req(4'b0001);
        cycles_to_start(n);
        pulse_req(4'b1000);
        chk("mid_pending", 32'(o_pending), 32'b1000);
        #2 iRstn = 1'b0;
        #1;
        chk("arst_start",   32'(o_start),   32'd0);
        chk("arst_mode",    32'(o_c_mode),  32'd0);
        chk("arst_data",    o_dec_data,     32'd0);
        chk("arst_busy",    32'(o_busy),    32'd0);
        chk("arst_pending", 32'(o_pending), 32'd0);
        chk("arst_drop",    32'(o_drop),    32'd0);
        chk("arst_timeout", 32'(o_timeout), 32'd0);
        @(negedge iClk);
        iRstn = 1'b1;
        saw = 1'b0;
        repeat (30) begin
            @(negedge iClk);
            saw = saw | o_start | o_timeout | o_busy;
        end
        chk("post_rst_quiet", 32'(saw), 32'd0);
        push_exp(2'd2, i_sr04_data);
        pulse_req(4'b0100);
        cycles_to_start(n);
        send_lf();
        wait_idle();
        repeat (3) @(negedge iClk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
